posit_regime_pack: RTL and testbench



---
 rtl/posit_regime_pack_pkg.sv | 31 +++
 rtl/posit_regime_pack_if.sv | 35 +++
 rtl/posit_regime_pack_rne_round.sv | 30 +++
 rtl/posit_regime_pack.sv | 140 ++++++++++++++
 tb/tb_posit_regime_pack.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/posit_regime_pack_pkg.sv
// Shared posit encoding helpers: field widths, special encodings and regime length.
package posit_regime_pack_pkg;

  localparam int unsigned MAX_N = 64;

  typedef logic [MAX_N-1:0] posit_word_t;

  localparam posit_word_t POSIT_MINPOS = posit_word_t'(1);

  function automatic int unsigned regime_cnt_width(input int unsigned n);
    return $clog2(n);
  endfunction

  // A zero-width exponent field is still carried on a one-bit port.
  function automatic int unsigned exp_field_width(input int unsigned es);
    return (es > 0) ? es : 1;
  endfunction

  function automatic posit_word_t posit_nar(input int unsigned n);
    return posit_word_t'(1) << (n - 1);
  endfunction

  function automatic posit_word_t posit_maxpos(input int unsigned n);
    return (posit_word_t'(1) << (n - 1)) - posit_word_t'(1);
  endfunction

  function automatic int unsigned regime_len(input int k);
    return (k >= 0) ? unsigned'(k + 2) : unsigned'(1 - k);
  endfunction

endpackage

// File: rtl/posit_regime_pack_if.sv
// Beat-level interface of the posit packer: decoded input beat and packed output beat.
interface posit_regime_pack_if
    import posit_regime_pack_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned ES = 0,
    parameter int unsigned F  = N
);

    localparam int unsigned S  = regime_cnt_width(N);
    localparam int unsigned EW = exp_field_width(ES);

    logic                in_valid;
    logic                in_ready;
    logic                in_sign;
    logic signed [S:0]   in_k;
    logic [EW-1:0]       in_exp;
    logic [F-1:0]        in_frac;
    logic                in_zero;
    logic                in_nar;
    logic                out_valid;
    logic                out_ready;
    logic [N-1:0]        out_posit;

    modport master (
        output in_valid, in_sign, in_k, in_exp, in_frac, in_zero, in_nar, out_ready,
        input  in_ready, out_valid, out_posit
    );

    modport slave (
        input  in_valid, in_sign, in_k, in_exp, in_frac, in_zero, in_nar, out_ready,
        output in_ready, out_valid, out_posit
    );

endinterface

// File: rtl/posit_regime_pack_rne_round.sv
// Round-to-nearest-even of the posit body; result never wraps past maxpos or falls to zero.
module rne_round
    import posit_regime_pack_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-2:0] body_i,
    input  logic         guard_i,
    input  logic         sticky_i,
    output logic [N-2:0] body_o
);

    localparam posit_word_t MAXPOS_W = posit_maxpos(N);

    logic         round_up;
    logic [N-1:0] sum;

    always_comb begin
        round_up = guard_i & (sticky_i | body_i[0]);
        sum      = {1'b0, body_i} + {{(N-1){1'b0}}, round_up};
        if (sum[N-1]) begin
            body_o = MAXPOS_W[N-2:0];
        end else if (sum[N-2:0] == '0) begin
            body_o = POSIT_MINPOS[N-2:0];
        end else begin
            body_o = sum[N-2:0];
        end
    end

endmodule

// File: rtl/posit_regime_pack.sv
// Two-stage posit encoder back end: regime/body construction, then RNE rounding and sign.
module posit_regime_pack
    import posit_regime_pack_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned ES = 0,
    parameter int unsigned F  = N
) (
    input  logic               clk,
    input  logic               rst,
    posit_regime_pack_if.slave bus
);

    localparam int unsigned BW = N - 1;
    localparam int unsigned TL = ES + F;
    localparam int unsigned WW = TL + 2 * N;
    localparam posit_word_t NAR_W = posit_nar(N);

    logic          advance;

    logic          s1_valid_q;
    logic          s1_sign_q;
    logic          s1_zero_q;
    logic          s1_nar_q;
    logic [BW-1:0] s1_body_q;
    logic          s1_guard_q;
    logic          s1_sticky_q;

    logic [BW-1:0] s1_body_d;
    logic          s1_guard_d;
    logic          s1_sticky_d;

    logic          out_valid_q;
    logic [N-1:0]  out_posit_q;
    logic [N-1:0]  out_posit_d;

    logic [TL-1:0] tail;
    logic [WW-1:0] reg_w;
    logic [WW-1:0] tail_w;
    logic [WW-1:0] word_w;
    int            k_int;
    int unsigned   len;

    logic [BW-1:0] rounded;
    logic [N-1:0]  mag;

    if (ES > 0) begin : g_exp
        assign tail = {bus.in_exp, bus.in_frac};
    end else begin : g_noexp
        logic unused_exp;
        assign unused_exp = ^bus.in_exp;
        assign tail       = bus.in_frac;
    end

    // Stage 1: regime run is laid MSB-first, exp/frac follow right after its terminator.
    // The word is wide enough that no tail bit is shifted out, so sticky sees them all.
    always_comb begin
        k_int       = int'(bus.in_k);
        len         = regime_len(k_int);
        reg_w       = '0;
        tail_w      = '0;
        word_w      = '0;
        s1_body_d   = '0;
        s1_guard_d  = 1'b0;
        s1_sticky_d = 1'b0;
        if (k_int >= int'(N) - 2) begin
            s1_body_d = '1;
        end else if (k_int <= 1 - int'(N)) begin
            s1_body_d = BW'(1);
        end else begin
            if (k_int >= 0) begin
                reg_w = ~({WW{1'b1}} >> (k_int + 1));
            end else begin
                reg_w = {1'b1, {(WW-1){1'b0}}} >> (-k_int);
            end
            tail_w      = {tail, {(2*N){1'b0}}} >> len;
            word_w      = reg_w | tail_w;
            s1_body_d   = word_w[WW-1 -: BW];
            s1_guard_d  = word_w[WW-1-BW];
            s1_sticky_d = |word_w[WW-2-BW:0];
        end
    end

    rne_round #(
        .N (N)
    ) u_rne_round (
        .body_i   (s1_body_q),
        .guard_i  (s1_guard_q),
        .sticky_i (s1_sticky_q),
        .body_o   (rounded)
    );

    // Stage 2: specials bypass rounding and negation entirely.
    always_comb begin
        mag = {1'b0, rounded};
        if (s1_nar_q) begin
            out_posit_d = NAR_W[N-1:0];
        end else if (s1_zero_q) begin
            out_posit_d = '0;
        end else if (s1_sign_q) begin
            out_posit_d = -mag;
        end else begin
            out_posit_d = mag;
        end
    end

    assign advance       = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_q;
    assign bus.out_posit = out_posit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_nar_q    <= 1'b0;
            s1_body_q   <= '0;
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_posit_q <= '0;
        end else if (advance) begin
            s1_valid_q  <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign_q   <= bus.in_sign;
                s1_zero_q   <= bus.in_zero;
                s1_nar_q    <= bus.in_nar;
                s1_body_q   <= s1_body_d;
                s1_guard_q  <= s1_guard_d;
                s1_sticky_q <= s1_sticky_d;
            end
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_posit_q <= out_posit_d;
            end
        end
    end

endmodule

// File: tb/tb_posit_regime_pack.sv
// Scoreboard bench for posit_regime_pack: directed vectors, stall/reset scenarios, random beats.
module tb_posit_regime_pack;

    localparam int N  = 8;
    localparam int ES = 0;
    localparam int F  = 8;
    localparam int KW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    posit_regime_pack_if #(.N(N), .ES(ES), .F(F)) bus ();

    posit_regime_pack #(.N(N), .ES(ES), .F(F)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int rdy_mode = 0;
    int pat_i    = 0;

    logic [N-1:0] exp_q[$];
    string        name_q[$];

    logic [N-1:0] held;
    bit           held_v = 1'b0;
    string        mon_nm;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference: spell out the bit string regime|frac, keep N-1 bits, round half to even.
    function automatic logic [N-1:0] ref_posit(input bit sgn, input int k, input logic [F-1:0] fr,
                                               input bit z, input bit nr);
        bit q[$];
        int body;
        bit g;
        bit st;
        if (nr) return logic'(1) << (N - 1);
        if (z) return '0;
        if (k >= N - 2) begin
            body = (1 << (N - 1)) - 1;
        end else if (k <= -(N - 1)) begin
            body = 1;
        end else begin
            if (k >= 0) begin
                repeat (k + 1) q.push_back(1'b1);
                q.push_back(1'b0);
            end else begin
                repeat (-k) q.push_back(1'b0);
                q.push_back(1'b1);
            end
            for (int i = F - 1; i >= 0; i--) q.push_back(fr[i]);
            body = 0;
            for (int i = 0; i < N - 1; i++) body = body * 2 + int'(q[i]);
            g  = q[N-1];
            st = 1'b0;
            for (int i = N; i < q.size(); i++) st = st | q[i];
            if (g && (st || (body % 2 == 1))) body++;
            if (body > (1 << (N - 1)) - 1) body = (1 << (N - 1)) - 1;
            if (body == 0) body = 1;
        end
        return sgn ? N'((1 << N) - body) : N'(body);
    endfunction

    task automatic tick();
        @(negedge clk);
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = (pat_i % 3 == 0);
            2:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
        endcase
        pat_i++;
        #1;
    endtask

    task automatic idle1();
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input string nm, input bit sgn, input int k, input logic [F-1:0] fr,
                        input bit z, input bit nr, input logic [N-1:0] want);
        int waited = 0;
        tick();
        bus.in_valid = 1'b1;
        bus.in_sign  = sgn;
        bus.in_k     = KW'(k);
        bus.in_exp   = 1'($urandom_range(0, 1));
        bus.in_frac  = fr;
        bus.in_zero  = z;
        bus.in_nar   = nr;
        while (!bus.in_ready) begin
            if (waited > 100) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout %s actual=no_accept required=accept", nm);
                bus.in_valid = 1'b0;
                return;
            end
            tick();
            waited++;
        end
        exp_q.push_back(want);
        name_q.push_back(nm);
    endtask

    task automatic rnd_beat();
        bit          sgn = 1'($urandom_range(0, 1));
        int          k   = int'($urandom_range(0, 15)) - 8;
        logic [F-1:0] fr = F'($urandom);
        bit          z   = ($urandom_range(0, 15) == 0);
        bit          nr  = ($urandom_range(0, 15) == 0);
        send("rand", sgn, k, fr, z, nr, ref_posit(sgn, k, fr, z, nr));
    endtask

    // Monitor: samples after drivers settle each negedge; a transfer happens at the next posedge.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            held_v = 1'b0;
        end else begin
            check("in_ready_rule", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
            if (held_v) begin
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_stable", 32'(bus.out_posit), 32'(held));
            end
            held_v = bus.out_valid && !bus.out_ready;
            held   = bus.out_posit;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%0h required=none", bus.out_posit);
                end else begin
                    mon_nm = name_q.pop_front();
                    check(mon_nm, 32'(bus.out_posit), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_k      = '0;
        bus.in_exp    = '0;
        bus.in_frac   = '0;
        bus.in_zero   = 1'b0;
        bus.in_nar    = 1'b0;
        bus.out_ready = 1'b0;
        rdy_mode      = 0;

        repeat (3) tick();
        rst = 1'b0;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_posit", 32'(bus.out_posit), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        send("k0", 0, 0, 8'h00, 0, 0, 8'h40);
        send("k1", 0, 1, 8'h00, 0, 0, 8'h60);
        send("km1", 0, -1, 8'h00, 0, 0, 8'h20);
        send("k0_neg", 1, 0, 8'h00, 0, 0, 8'hC0);
        send("tie_even", 0, 0, 8'b1000_0100, 0, 0, 8'h50);
        send("tie_odd", 0, 0, 8'b1000_1100, 0, 0, 8'h52);
        send("sticky", 0, 0, 8'b1000_0101, 0, 0, 8'h51);
        send("k7_sat", 0, 7, 8'h00, 0, 0, 8'h7F);
        send("k6_ff", 0, 6, 8'hFF, 0, 0, 8'h7F);
        send("k5_ff_clamp", 0, 5, 8'hFF, 0, 0, 8'h7F);
        send("k5_zero", 0, 5, 8'h00, 0, 0, 8'h7E);
        send("km7_min", 0, -7, 8'hFF, 0, 0, 8'h01);
        send("km8_min", 0, -8, 8'h00, 0, 0, 8'h01);
        send("km8_min_neg", 1, -8, 8'h00, 0, 0, 8'hFF);
        send("km6_round", 0, -6, 8'h80, 0, 0, 8'h02);
        send("km6_down", 0, -6, 8'h40, 0, 0, 8'h01);
        send("nar_zero", 0, 0, 8'h55, 1, 1, 8'h80);
        send("nar_neg", 1, 3, 8'h12, 0, 1, 8'h80);
        send("zero", 1, 2, 8'hAA, 1, 0, 8'h00);
        idle1();

        // Stream under a 1,0,0 out_ready pattern.
        repeat (4) idle1();
        pat_i    = 0;
        rdy_mode = 1;
        for (int i = 0; i < 6; i++) begin
            send("stream", 0, i - 3, 8'(8'h11 * (i + 1)), 0, 0,
                 ref_posit(0, i - 3, 8'(8'h11 * (i + 1)), 0, 0));
        end
        idle1();
        rdy_mode = 0;
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) idle1();
        check("stream_drained", 32'(exp_q.size()), 32'd0);

        // Reset with two beats in flight, downstream stalled.
        rdy_mode = 3;
        send("flight_a", 0, 2, 8'h33, 0, 0, 8'h00);
        send("flight_b", 1, 1, 8'h44, 0, 0, 8'h00);
        tick();
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        exp_q.delete();
        name_q.delete();
        tick();
        rst = 1'b0;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_posit", 32'(bus.out_posit), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        rdy_mode = 0;
        send("post_rst", 0, 0, 8'h00, 0, 0, 8'h40);
        idle1();
        check("latency_t1_valid", 32'(bus.out_valid), 32'd0);
        idle1();
        check("latency_t2_valid", 32'(bus.out_valid), 32'd1);
        check("latency_t2_posit", 32'(bus.out_posit), 32'h40);

        // Random beats with random gaps and random backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) idle1();
            rnd_beat();
        end
        idle1();
        rdy_mode = 0;
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) idle1();
        check("final_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) idle1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
